mem_data_access: RTL



---
 rtl/mem_data_access_pkg.sv | 63 ++++++
 rtl/mem_data_access_if.sv | 24 ++
 rtl/mem_data_access_load_align.sv | 31 +++
 rtl/mem_data_access.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_data_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
// Op decode, alignment rules and store lane replication live here.
package mem_access_pkg;

    // Nine op codes need four bits, so the op field is one bit wider than three.
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        LB,
        LBU,
        LH,
        LHU,
        LW,
        SB,
        SH,
        SW
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [1:0] op_size(input mem_op_t op);
        case (op)
            LH, LHU, SH: return SZ_H;
            LW, SW:      return SZ_W;
            default:     return SZ_B;
        endcase
    endfunction

    function automatic logic op_aligned(input mem_op_t op, input logic [1:0] addr_lo);
        case (op)
            LH, LHU, SH: return ~addr_lo[0];
            LW, SW:      return (addr_lo == 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

    // Replicate the store source across every lane the access size can hit.
    function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] wdata);
        case (op)
            SB:      return {4{wdata[7:0]}};
            SH:      return {2{wdata[15:0]}};
            SW:      return wdata;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_access_if.sv
// SRAM-like data bus with req / addr_ok / data_ok handshake.
interface mem_data_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_data_access_load_align.sv
// Little-endian load lane select with sign or zero extension.
module mem_load_align
    import mem_access_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (op_i)
            LB:      data_o = {{24{byte_v[7]}}, byte_v};
            LBU:     data_o = {24'd0, byte_v};
            LH:      data_o = {{16{half_v[15]}}, half_v};
            LHU:     data_o = {16'd0, half_v};
            LW:      data_o = rdata_i;
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/mem_data_access.sv
// MEM-stage data-memory access: alignment check, bus handshake FSM,
// pipeline stall request and extended load result.
module mem_data_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 mem_valid_i,
    input  mem_op_t              mem_op_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          mem_wdata_i,
    input  logic                 mem_excp_i,
    input  logic                 flush_i,
    output logic                 stall_req_o,
    output logic [31:0]          load_data_o,
    output logic                 load_valid_o,
    output logic                 adel_o,
    output logic                 ades_o,
    mem_data_access_if.master    bus
);
    mem_state_t        state_q;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              cancel_q;
    logic [31:0]       result_q;

    logic        live;
    logic        aligned;
    logic        idle;
    logic        start;
    logic [31:0] ext_rdata;

    // Gating with rst_n_i keeps the combinational outputs at 0 during reset.
    assign live    = rst_n_i & mem_valid_i & ~mem_excp_i & ~flush_i;
    assign aligned = op_aligned(mem_op_i, mem_addr_i[1:0]);
    assign idle    = (state_q == IDLE);
    assign start   = idle & live & aligned & (is_load(mem_op_i) | is_store(mem_op_i));

    mem_load_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (bus.data_rdata),
        .data_o    (ext_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            op_q     <= MEM_NOP;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_B;
            cancel_q <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= mem_op_i;
                        addr_q  <= mem_addr_i[ADDR_W-1:0];
                        wdata_q <= store_data(mem_op_i, mem_wdata_i);
                        size_q  <= op_size(mem_op_i);
                        state_q <= REQ;
                    end
                end
                // An issued request is never withdrawn; a flush only marks it cancelled.
                REQ: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (bus.data_addr_ok && bus.data_data_ok) begin
                        if (is_load(op_q)) result_q <= ext_rdata;
                        state_q <= DONE;
                    end else if (bus.data_addr_ok) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (bus.data_data_ok) begin
                        if (is_load(op_q)) result_q <= ext_rdata;
                        state_q <= DONE;
                    end
                end
                default: begin
                    cancel_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_req   = (state_q == REQ);
    assign bus.data_wr    = is_store(op_q);
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    assign stall_req_o  = start | (state_q == REQ) | (state_q == WAIT);
    assign adel_o       = idle & live & is_load(mem_op_i) & ~aligned;
    assign ades_o       = idle & live & is_store(mem_op_i) & ~aligned;
    assign load_valid_o = (state_q == DONE) & is_load(op_q) & ~cancel_q & ~flush_i;
    assign load_data_o  = result_q;
endmodule
